// File: rtl/bcd_mod_counter_pkg.sv
// Shared constants and types for the two-digit BCD modulus counter.
// The digit width and BCD ceiling are defined only here.
package bcd_mod_counter_pkg;

    localparam int DIGIT_W     = 4;
    localparam int MODULUS_MIN = 2;
    localparam int MODULUS_MAX = 100;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t BCD_MAX = digit_t'(9);

    typedef enum logic [1:0] {
        CMD_HOLD,
        CMD_COUNT,
        CMD_LOAD,
        CMD_CLEAR
    } cmd_e;

    // One mod-10 step in either direction.
    function automatic digit_t bcd_step(input digit_t q, input logic up);
        if (up) begin
            return (q == BCD_MAX) ? digit_t'(0) : digit_t'(q + 1'b1);
        end
        return (q == digit_t'(0)) ? BCD_MAX : digit_t'(q - 1'b1);
    endfunction

endpackage

// File: rtl/bcd_mod_counter_digit.sv
// Single mod-10 up/down BCD digit with synchronous clear, load and enable.
// o_tc flags the digit value at which a step in the current direction rolls over.
module bcd_digit_counter
    import bcd_mod_counter_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_clr_n,
    input  logic   i_load,
    input  digit_t i_load_val,
    input  logic   i_en,
    input  logic   i_up,
    output digit_t o_q,
    output logic   o_tc
);

    digit_t r_q;
    cmd_e   w_cmd;

    always_comb begin
        w_cmd = CMD_HOLD;
        if (!i_clr_n) begin
            w_cmd = CMD_CLEAR;
        end else if (i_load) begin
            w_cmd = CMD_LOAD;
        end else if (i_en) begin
            w_cmd = CMD_COUNT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_q <= '0;
        end else begin
            case (w_cmd)
                CMD_LOAD:  r_q <= i_load_val;
                CMD_COUNT: r_q <= bcd_step(r_q, i_up);
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_q  = r_q;
    assign o_tc = i_up ? (r_q == BCD_MAX) : (r_q == digit_t'(0));

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter with arbitrary modulus 2..100, cascadable via ENT/RCO.
// Modulus wrap and illegal-load handling live here; the digits are plain mod-10 cells.
module bcd_mod_counter
    import bcd_mod_counter_pkg::*;
#(
    parameter int MODULUS = 60,
    parameter int Delay   = 0
) (
    input  logic   CLK,
    input  logic   CLR_n,
    input  logic   LOAD_n,
    input  logic   ENP,
    input  logic   ENT,
    input  logic   UP,
    input  digit_t D_TENS,
    input  digit_t D_ONES,
    output digit_t Q_TENS,
    output digit_t Q_ONES,
    output logic   RCO,
    output logic   ERR
);

    if (MODULUS < MODULUS_MIN || MODULUS > MODULUS_MAX) begin : g_bad_modulus
        $fatal(1, "bcd_mod_counter: MODULUS must be within 2..100");
    end
    // Delay is accepted for interface compatibility; synthesized outputs are zero-delay.
    if (Delay < 0) begin : g_bad_delay
        $fatal(1, "bcd_mod_counter: Delay must be non-negative");
    end

    localparam digit_t     LAST_TENS = digit_t'((MODULUS - 1) / 10);
    localparam digit_t     LAST_ONES = digit_t'((MODULUS - 1) % 10);
    localparam logic [7:0] LAST_V    = 8'(MODULUS - 1);

    digit_t     w_q_tens;
    digit_t     w_q_ones;
    logic       w_ones_tc;
    logic       w_tens_tc;
    logic       w_at_end;
    logic       w_count;
    logic       w_wrap;
    logic       w_load;
    logic       w_load_bad;
    logic [7:0] w_d_value;
    digit_t     w_ones_load_val;
    digit_t     w_tens_load_val;
    logic       r_err;

    assign w_d_value  = ({4'b0, D_TENS} * 8'd10) + {4'b0, D_ONES};
    assign w_load_bad = (D_TENS > BCD_MAX) || (D_ONES > BCD_MAX) || (w_d_value > LAST_V);

    // Terminal value in the current direction: MODULUS-1 going up, 0 going down.
    assign w_at_end = UP ? ((w_q_tens == LAST_TENS) && (w_q_ones == LAST_ONES))
                         : (w_ones_tc && w_tens_tc);

    assign w_count = LOAD_n && ENP && ENT;
    assign w_wrap  = w_count && w_at_end;
    assign w_load  = !LOAD_n || w_wrap;

    always_comb begin
        w_ones_load_val = UP ? digit_t'(0) : LAST_ONES;
        w_tens_load_val = UP ? digit_t'(0) : LAST_TENS;
        if (!LOAD_n) begin
            w_ones_load_val = w_load_bad ? digit_t'(0) : D_ONES;
            w_tens_load_val = w_load_bad ? digit_t'(0) : D_TENS;
        end
    end

    bcd_digit_counter u_ones (
        .i_clk      (CLK),
        .i_clr_n    (CLR_n),
        .i_load     (w_load),
        .i_load_val (w_ones_load_val),
        .i_en       (w_count),
        .i_up       (UP),
        .o_q        (w_q_ones),
        .o_tc       (w_ones_tc)
    );

    bcd_digit_counter u_tens (
        .i_clk      (CLK),
        .i_clr_n    (CLR_n),
        .i_load     (w_load),
        .i_load_val (w_tens_load_val),
        .i_en       (w_count && w_ones_tc),
        .i_up       (UP),
        .o_q        (w_q_tens),
        .o_tc       (w_tens_tc)
    );

    // Sticky until an explicit clear; loads and counts never drop it.
    always_ff @(posedge CLK) begin
        if (!CLR_n) begin
            r_err <= 1'b0;
        end else if (!LOAD_n && w_load_bad) begin
            r_err <= 1'b1;
        end
    end

    assign Q_TENS = w_q_tens;
    assign Q_ONES = w_q_ones;
    assign RCO    = ENT && w_at_end;
    assign ERR    = r_err;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench: table-driven vectors on mod-60 and mod-24 instances,
// plus a hand-written seconds->minutes cascade, all checked through a scoreboard queue.
module tb_bcd_mod_counter;

    logic       CLK = 1'b0;
    logic       clr_n, load_n, enp, ent, up;
    logic [3:0] d_tens, d_ones;
    logic [3:0] q60_t, q60_o, q24_t, q24_o;
    logic       rco60, err60, rco24, err24;

    logic       c_clr_n, c_load_n, c_ent;
    logic [3:0] c_dmt, c_dmo, c_dst, c_dso;
    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic       min_rco, min_err, sec_rco, sec_err;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    bcd_mod_counter #(.MODULUS(60), .Delay(0)) dut60 (
        .CLK(CLK), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(ent), .UP(up),
        .D_TENS(d_tens), .D_ONES(d_ones), .Q_TENS(q60_t), .Q_ONES(q60_o),
        .RCO(rco60), .ERR(err60)
    );

    bcd_mod_counter #(.MODULUS(24), .Delay(0)) dut24 (
        .CLK(CLK), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(ent), .UP(up),
        .D_TENS(d_tens), .D_ONES(d_ones), .Q_TENS(q24_t), .Q_ONES(q24_o),
        .RCO(rco24), .ERR(err24)
    );

    bcd_mod_counter #(.MODULUS(60), .Delay(0)) u_sec (
        .CLK(CLK), .CLR_n(c_clr_n), .LOAD_n(c_load_n), .ENP(1'b1), .ENT(c_ent), .UP(1'b1),
        .D_TENS(c_dst), .D_ONES(c_dso), .Q_TENS(sec_t), .Q_ONES(sec_o),
        .RCO(sec_rco), .ERR(sec_err)
    );

    bcd_mod_counter #(.MODULUS(60), .Delay(0)) u_min (
        .CLK(CLK), .CLR_n(c_clr_n), .LOAD_n(c_load_n), .ENP(1'b1), .ENT(sec_rco), .UP(1'b1),
        .D_TENS(c_dmt), .D_ONES(c_dmo), .Q_TENS(min_t), .Q_ONES(min_o),
        .RCO(min_rco), .ERR(min_err)
    );

    typedef struct {
        int         sel;
        logic       clr_n, load_n, enp, ent, up;
        logic [3:0] dt, dn;
        logic [3:0] et, eo;
        logic       eerr, erco;
    } vec_t;

    typedef struct {
        string      name;
        int         sel;   // 0 mod60, 1 mod24, 2 minutes, 3 seconds
        logic [3:0] et, eo;
        logic       eerr, erco;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(int sel, logic c, logic l, logic p, logic t, logic u,
                                logic [3:0] dt, logic [3:0] dn,
                                logic [3:0] et, logic [3:0] eo, logic eerr, logic erco);
        vec_t v;
        v.sel = sel; v.clr_n = c; v.load_n = l; v.enp = p; v.ent = t; v.up = u;
        v.dt = dt; v.dn = dn; v.et = et; v.eo = eo; v.eerr = eerr; v.erco = erco;
        return v;
    endfunction

    function automatic exp_t mke(string name, int sel, logic [3:0] et, logic [3:0] eo,
                                 logic eerr, logic erco);
        exp_t e;
        e.name = name; e.sel = sel; e.et = et; e.eo = eo; e.eerr = eerr; e.erco = erco;
        return e;
    endfunction

    task automatic check_one();
        exp_t       e;
        logic [3:0] at, ao;
        logic       aerr, arco;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got no expected entry, want one");
            return;
        end
        e = sb.pop_front();
        case (e.sel)
            0:       begin at = q60_t; ao = q60_o; aerr = err60;   arco = rco60;   end
            1:       begin at = q24_t; ao = q24_o; aerr = err24;   arco = rco24;   end
            2:       begin at = min_t; ao = min_o; aerr = min_err; arco = min_rco; end
            default: begin at = sec_t; ao = sec_o; aerr = sec_err; arco = sec_rco; end
        endcase
        if ({at, ao, aerr, arco} !== {e.et, e.eo, e.eerr, e.erco}) begin
            bad++;
            $display("FAIL %s: got Q=%0d%0d ERR=%b RCO=%b, want Q=%0d%0d ERR=%b RCO=%b",
                     e.name, at, ao, aerr, arco, e.et, e.eo, e.eerr, e.erco);
        end else begin
            $display("ok   %s: Q=%0d%0d ERR=%b RCO=%b", e.name, at, ao, aerr, arco);
        end
    endtask

    task automatic casc_step(string name, logic c, logic l,
                             logic [3:0] dmt, logic [3:0] dmo, logic [3:0] dst, logic [3:0] dso,
                             logic [3:0] emt, logic [3:0] emo, logic [3:0] est, logic [3:0] eso,
                             logic emrco, logic esrco);
        c_clr_n = c; c_load_n = l; c_ent = 1'b1;
        c_dmt = dmt; c_dmo = dmo; c_dst = dst; c_dso = dso;
        sb.push_back(mke({name, "_min"}, 2, emt, emo, 1'b0, emrco));
        sb.push_back(mke({name, "_sec"}, 3, est, eso, 1'b0, esrco));
        @(posedge CLK); #1;
        check_one();
        check_one();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_n = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b0; up = 1'b1;
        d_tens = 4'd0; d_ones = 4'd0;
        c_clr_n = 1'b0; c_load_n = 1'b1; c_ent = 1'b1;
        c_dmt = 4'd0; c_dmo = 4'd0; c_dst = 4'd0; c_dso = 4'd0;

        //                sel clr ld enp ent up dt  dn   et eo err rco
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0)); // clear
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 5, 8,   5, 8, 0, 0)); // load 58
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0,   5, 9, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0,   0, 0, 0, 0)); // up wrap
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0,   0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 5, 9,   5, 9, 0, 1)); // load 59
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0,   5, 9, 0, 1)); // ENP=0 holds
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0,   5, 9, 0, 0)); // ENT=0 holds
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 6, 0,   0, 0, 1, 0)); // 60 illegal
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 10,  0, 0, 1, 0)); // 1A illegal
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0,   0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0,   0, 2, 1, 0)); // ERR sticky
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 1)); // clear, down RCO
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 4, 5,   0, 0, 0, 0)); // clear beats load
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 4, 5,   4, 5, 0, 0)); // load beats count
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0,   4, 6, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0,   4, 5, 0, 0)); // direction flip
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0,   4, 6, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4, 0,   4, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0,   3, 9, 0, 0)); // tens borrow
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0,   5, 9, 0, 0)); // down wrap
        vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 1)); // mod-24 section
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 1,   0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0,   2, 3, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0,   2, 2, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2, 4,   0, 0, 1, 0)); // 24 illegal
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 2, 3,   2, 3, 1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0,   0, 0, 1, 0));

        @(posedge CLK); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            clr_n = vecs[i].clr_n; load_n = vecs[i].load_n;
            enp = vecs[i].enp; ent = vecs[i].ent; up = vecs[i].up;
            d_tens = vecs[i].dt; d_ones = vecs[i].dn;
            sb.push_back(mke($sformatf("vec%0d", i), vecs[i].sel,
                             vecs[i].et, vecs[i].eo, vecs[i].eerr, vecs[i].erco));
            @(posedge CLK); #1;
            check_one();
        end

        //        name       clr ld  dmt dmo dst dso  emt emo est eso mrco srco
        casc_step("c_clear", 0, 1,  0,  0,  0,  0,   0,  0,  0,  0,  0,   0);
        casc_step("c_00_59", 1, 0,  0,  0,  5,  9,   0,  0,  5,  9,  0,   1);
        casc_step("c_01_00", 1, 1,  0,  0,  0,  0,   0,  1,  0,  0,  0,   0);
        casc_step("c_59_59", 1, 0,  5,  9,  5,  9,   5,  9,  5,  9,  1,   1);
        casc_step("c_00_00", 1, 1,  0,  0,  0,  0,   0,  0,  0,  0,  0,   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 SHALL have parameter MODULUS, default 60, count modulus; legal range 2..100.
REQ-002 SHALL have parameter Delay, default 0, simulation delay in ns applied to all outputs.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port CLR_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port LOAD_n  input  1  synchronous parallel load, active-low.
REQ-006 SHALL have port ENP  input  1  count enable, parallel.
REQ-007 SHALL have port ENT  input  1  count enable, trickle; also gates RCO.
REQ-008 SHALL have port UP  input  1  direction: 1 = up, 0 = down.
REQ-009 SHALL have port D_TENS  input  4  BCD tens digit for load.
REQ-010 SHALL have port D_ONES  input  4  BCD ones digit for load.
REQ-011 SHALL have port Q_TENS  output  4  current BCD tens digit.
REQ-012 SHALL have port Q_ONES  output  4  current BCD ones digit.
REQ-013 SHALL have port RCO  output  1  ripple carry/borrow to the next stage.
REQ-014 SHALL have port ERR  output  1  sticky illegal-load flag.

Function
REQ-015 SHALL hold value V = 10*Q_TENS + Q_ONES, always in 0..MODULUS-1 with both digits valid BCD (0..9).
REQ-016 SHALL apply per-edge priority: CLR_n low > LOAD_n low > count > hold.
REQ-017 SHALL count only when CLR_n=1, LOAD_n=1, ENP=1 and ENT=1; otherwise hold.
REQ-018 SHALL, when counting up, increment ones; ones 9->0 with tens+1; V=MODULUS-1 -> 0 (both digits 0).
REQ-019 SHALL, when counting down, decrement ones; ones 0->9 with tens-1; V=0 -> MODULUS-1.
REQ-020 SHALL, on load with both D digits <=9 and 10*D_TENS+D_ONES < MODULUS, set V to that value with ERR unchanged.
REQ-021 SHALL, on illegal load (either digit >9 or value >= MODULUS), set V=0 and ERR=1.
REQ-022 SHALL keep ERR at 1 until CLR_n is sampled low; loading and counting SHALL NOT clear it.
REQ-023 SHALL drive RCO combinationally as ENT AND (UP ? V==MODULUS-1 : V==0), independent of ENP and LOAD_n.
REQ-024 SHALL reflect a UP change mid-count on the next enabled edge only, with no extra step or skipped value.
REQ-025 SHALL give load, count and clear one-cycle latency: Q is updated on the same edge the command is sampled.
REQ-026 SHALL ensure that, with multiple instances cascaded on common CLK, ENT of stage k+1 = RCO of stage k and ENP tied to 1, wraps advance the next stage on the same edge.

Reset
REQ-027 SHALL, when CLR_n is sampled low, set Q_TENS=0, Q_ONES=0 and ERR=0; RCO then equals ENT AND (UP==0).
REQ-028 SHALL let CLR_n override any simultaneous LOAD_n or count on the same edge.
REQ-029 SHALL leave outputs X before the first CLR_n edge; the bench SHALL apply CLR_n first.

Structure
REQ-030 SHALL take BCD_MAX (9) and the digit width (4) from the shared catalog header, not from local literals.
REQ-031 SHALL instantiate two bcd_digit_counter sub-modules (ones, tens), each a mod-10 up/down BCD cell with sync load, enable and carry/borrow out.
REQ-032 SHALL implement the MODULUS wrap and illegal-load check in the top level.
REQ-033 SHALL be rejected at elaboration if MODULUS is outside 2..100.

Verification
REQ-034 SHALL cover up-count wrap: MODULUS=60, load 58, UP=1, enables=1, 3 edges -> Q 59,00,01; RCO=1 only while 59.
REQ-035 SHALL cover down-count wrap: MODULUS=24, load 01, UP=0, 3 edges -> Q 00,23,22; RCO=1 only while 00.
REQ-036 SHALL cover illegal load: MODULUS=60, D=6,0 -> Q=00, ERR=1; then D=1,A -> Q=00, ERR=1; count 2 edges -> 02, ERR still 1; CLR_n low -> 00, ERR=0.
REQ-037 SHALL cover priority: CLR_n=0, LOAD_n=0, enables=1 on the same edge -> Q=00; then LOAD_n=0, D=4,5, enables=1 -> Q=45, no increment.
REQ-038 SHALL cover enable gating: ENP=0, ENT=1 at V=59 -> Q holds, RCO=1; ENT=0 -> RCO=0, Q holds.
REQ-039 SHALL cover a cascade (mod-60 seconds into mod-60 minutes): from 00:59, 1 edge -> 01:00; from 59:59, 1 edge -> 00:00 with minutes RCO=1 during 59:59.
